// File: rtl/pong_pkg.sv
// Shared Pong timing constants: raster line length, ball geometry and serve position.
// Pure declarations; no logic, no latency, no flow control.
package pong_pkg;

    localparam int PONG_CNT_W         = 9;
    localparam int PONG_H_TOTAL       = 455;
    localparam int PONG_MOVE_STEP     = 2;
    localparam int PONG_BALL_W        = 4;
    localparam int PONG_CENTER_PRESET = 283;

    typedef enum logic {
        ST_HOLD = 1'b0,
        ST_PLAY = 1'b1
    } ball_state_e;

endpackage

// File: rtl/ball_dir_ff.sv
// Ball direction flip-flop: set wins alone, clear wins alone, simultaneous set+clear holds.
// One clock from set/clear to dir_o; no backpressure, accepts a hit every cycle.
module ball_dir_ff (
    input  logic clk7,
    input  logic rst,
    input  logic set_i,
    input  logic clr_i,
    output logic dir_o
);

    logic dir_q;
    logic dir_d;

    always_comb begin
        dir_d = dir_q;
        if (set_i && !clr_i) begin
            dir_d = 1'b1;
        end else if (clr_i && !set_i) begin
            dir_d = 1'b0;
        end
    end

    // Reset to "moving right" so the first serve heads toward the right paddle.
    always_ff @(posedge clk7 or posedge rst) begin
        if (rst) begin
            dir_q <= 1'b1;
        end else begin
            dir_q <= dir_d;
        end
    end

    assign dir_o = dir_q;

endmodule

// File: rtl/ball_horizontal_counter.sv
// Ball horizontal counter: line-period counter whose reload shifts by MOVE_STEP per line while moving.
// hball is decoded from registers only (zero input-to-output path); no backpressure.
module ball_horizontal_counter
    import pong_pkg::*;
#(
    parameter int CNT_W         = PONG_CNT_W,
    parameter int H_TOTAL       = PONG_H_TOTAL,
    parameter int MOVE_STEP     = PONG_MOVE_STEP,
    parameter int BALL_W        = PONG_BALL_W,
    parameter int CENTER_PRESET = PONG_CENTER_PRESET
) (
    input  logic             clk7,
    input  logic             rst,
    input  logic             vreset,
    input  logic             move,
    input  logic             serve,
    input  logic             hit_left,
    input  logic             hit_right,
    output logic             hball,
    output logic             ball_dir,
    output logic [CNT_W-1:0] ball_hcnt
);

    localparam int CNT_SPAN = 1 << CNT_W;

    localparam logic [CNT_W-1:0] CNT_MAX     = CNT_W'(CNT_SPAN - 1);
    localparam logic [CNT_W-1:0] RL_STAT     = CNT_W'(CNT_SPAN - H_TOTAL);
    localparam logic [CNT_W-1:0] RL_LEFT     = CNT_W'(CNT_SPAN - H_TOTAL + MOVE_STEP);
    localparam logic [CNT_W-1:0] RL_RIGHT    = CNT_W'(CNT_SPAN - H_TOTAL - MOVE_STEP);
    localparam logic [CNT_W-1:0] HBALL_START = CNT_W'(CNT_SPAN - BALL_W);
    localparam logic [CNT_W-1:0] CENTER      = CNT_W'(CENTER_PRESET);

    ball_state_e      state_q;
    ball_state_e      state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             dir;

    ball_dir_ff u_dir (
        .clk7  (clk7),
        .rst   (rst),
        .set_i (hit_left),
        .clr_i (hit_right),
        .dir_o (dir)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_HOLD: if (vreset && serve) state_d = ST_PLAY;
            ST_PLAY: if (!serve)          state_d = ST_HOLD;
            default:                      state_d = ST_HOLD;
        endcase
    end

    // A shorter line (larger reload) moves the ball left; a longer line moves it right.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (state_q == ST_HOLD && vreset) begin
            cnt_d = CENTER;
        end else if (cnt_q == CNT_MAX) begin
            if (state_q == ST_PLAY && move) begin
                cnt_d = dir ? RL_RIGHT : RL_LEFT;
            end else begin
                cnt_d = RL_STAT;
            end
        end
    end

    always_ff @(posedge clk7 or posedge rst) begin
        if (rst) begin
            state_q <= ST_HOLD;
            cnt_q   <= CENTER;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign hball     = (state_q == ST_PLAY) && (cnt_q >= HBALL_START);
    assign ball_dir  = dir;
    assign ball_hcnt = cnt_q;

endmodule
